// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract datapath.
package adder_pkg;

  // Operation mode carried with every op
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Pipeline depth: one stage per CHUNK-bit slice
  function automatic int unsigned num_stages(input int unsigned width,
                                             input int unsigned chunk);
    return (chunk == 0) ? 0 : width / chunk;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit slice adder.
// Ports:
//   a_i, b_i   slice operands
//   c_i        carry into the slice LSB
//   sum_o      slice sum
//   c_o        carry out of the slice MSB
//   c_msb_o    carry into the slice MSB (for signed overflow detection)
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             c_o,
  output logic             c_msb_o
);

  localparam int unsigned SUM_W = CHUNK + 1;

  assign {c_o, sum_o} = SUM_W'(a_i) + SUM_W'(b_i) + SUM_W'(c_i);

  // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin
  assign c_msb_o = a_i[CHUNK-1] ^ b_i[CHUNK-1] ^ sum_o[CHUNK-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor, one CHUNK-bit slice per stage,
// elastic valid/ready handshake, latency STAGES cycles, 1 op/cycle.
// Ports:
//   clk, rst              clock, async active-high reset
//   in_valid/in_ready     operand handshake (a, b, c_in, sub)
//   sub                   0: a+b+c_in, 1: a+~b+1 (c_in ignored)
//   out_valid/out_ready   result handshake (sum, c_out, ovf, chunk_carry)
//   c_out                 carry out of MSB (sub: 1 = no borrow)
//   ovf                   signed overflow
//   chunk_carry           carry out of each slice, bit k = slice k
module pipelined_add_sub
  import adder_pkg::*;
#(
  parameter  int unsigned WIDTH  = 16,
  parameter  int unsigned CHUNK  = 4,
  localparam int unsigned STAGES = num_stages(WIDTH, CHUNK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              c_in,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  sum,
  output logic              c_out,
  output logic              ovf,
  output logic [STAGES-1:0] chunk_carry
);

  if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("pipelined_add_sub: WIDTH (%0d) must be a nonzero multiple of CHUNK (%0d)",
           WIDTH, CHUNK);
  end

  // Stage registers
  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  a_q     [STAGES];
  logic [WIDTH-1:0]  b_q     [STAGES];
  logic [WIDTH-1:0]  sum_q   [STAGES];
  logic              carry_q [STAGES];
  logic              mode_q  [STAGES];
  logic              ovf_q   [STAGES];
  logic [STAGES-1:0] cc_q    [STAGES];

  // Next-state values produced by each stage's slice adder
  logic [STAGES-1:0] vin_d;
  logic [WIDTH-1:0]  a_d     [STAGES];
  logic [WIDTH-1:0]  b_d     [STAGES];
  logic [WIDTH-1:0]  sum_d   [STAGES];
  logic              carry_d [STAGES];
  logic              mode_d  [STAGES];
  logic              ovf_d   [STAGES];
  logic [STAGES-1:0] cc_d    [STAGES];

  logic [STAGES:0]   ready_c;

  // Elastic ready chain, evaluated from the output back to the input
  always_comb begin
    ready_c         = '0;
    ready_c[STAGES] = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      ready_c[k] = !valid_q[k] || ready_c[k+1];
    end
  end

  assign in_ready = ready_c[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0]  a_src;
    logic [WIDTH-1:0]  b_src;
    logic [WIDTH-1:0]  sum_src;
    logic [STAGES-1:0] cc_src;
    logic              cin_src;
    logic              mode_src;
    logic              v_src;
    logic [CHUNK-1:0]  slice_sum;
    logic              slice_cout;
    logic              slice_cmsb;
    logic [WIDTH-1:0]  sum_nxt;
    logic [STAGES-1:0] cc_nxt;

    // Stage 0 takes the port operands; subtraction folds into b and carry-in
    if (k == 0) begin : g_head
      assign a_src    = a;
      assign b_src    = (sub == MODE_SUB) ? ~b : b;
      assign cin_src  = (sub == MODE_ADD) ? c_in : 1'b1;
      assign sum_src  = '0;
      assign cc_src   = '0;
      assign mode_src = sub;
      assign v_src    = in_valid;
    end else begin : g_body
      assign a_src    = a_q[k-1];
      assign b_src    = b_q[k-1];
      assign cin_src  = carry_q[k-1];
      assign sum_src  = sum_q[k-1];
      assign cc_src   = cc_q[k-1];
      assign mode_src = mode_q[k-1];
      assign v_src    = valid_q[k-1];
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a_i     (a_src[k*CHUNK +: CHUNK]),
      .b_i     (b_src[k*CHUNK +: CHUNK]),
      .c_i     (cin_src),
      .sum_o   (slice_sum),
      .c_o     (slice_cout),
      .c_msb_o (slice_cmsb)
    );

    // Merge this slice's result into the partial sum and carry vector
    always_comb begin
      sum_nxt                     = sum_src;
      sum_nxt[k*CHUNK +: CHUNK]   = slice_sum;
      cc_nxt                      = cc_src;
      cc_nxt[k]                   = slice_cout;
    end

    assign vin_d[k]   = v_src;
    assign a_d[k]     = a_src;
    assign b_d[k]     = b_src;
    assign sum_d[k]   = sum_nxt;
    assign carry_d[k] = slice_cout;
    assign mode_d[k]  = mode_src;
    // Only the final stage's value reaches ovf (MSB slice)
    assign ovf_d[k]   = slice_cmsb ^ slice_cout;
    assign cc_d[k]    = cc_nxt;
  end

  // Stage registers: load when downstream can take, data only with a valid op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
        mode_q[k]  <= MODE_ADD;
        ovf_q[k]   <= 1'b0;
        cc_q[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (ready_c[k]) begin
          valid_q[k] <= vin_d[k];
          if (vin_d[k]) begin
            a_q[k]     <= a_d[k];
            b_q[k]     <= b_d[k];
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= carry_d[k];
            mode_q[k]  <= mode_d[k];
            ovf_q[k]   <= ovf_d[k];
            cc_q[k]    <= cc_d[k];
          end
        end
      end
    end
  end

  assign out_valid   = valid_q[STAGES-1];
  assign sum         = sum_q[STAGES-1];
  assign c_out       = carry_q[STAGES-1];
  assign ovf         = ovf_q[STAGES-1];
  assign chunk_carry = cc_q[STAGES-1];

endmodule
